// File: rtl/cond_pkg.sv
// cond_pkg: shared definitions for the conditional-execution controller.
//   - Condition-code encodings EQ..AL (plus the always-true 4'b1111 slot)
//   - NZCV bit positions inside the 4-bit flag vector
//   - RUN/RECOVER state type for the controller FSM
//   - Saturating 16-bit increment used by the performance counters
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        if (val == 16'hFFFF) begin
            return 16'hFFFF;
        end else begin
            return val + 16'h0001;
        end
    endfunction

endpackage

// File: rtl/cond_eval.sv
// cond_eval: purely combinational condition-code evaluator.
// Ports:
//   cond_i  [3:0]  instruction condition field
//   flags_i [3:0]  NZCV flags (bit3=N, bit2=Z, bit1=C, bit0=V)
//   pass_o         1 when the condition holds for the given flags
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       pass_o
);

    logic n_s;
    logic z_s;
    logic c_s;
    logic v_s;

    assign n_s = flags_i[FLAG_N];
    assign z_s = flags_i[FLAG_Z];
    assign c_s = flags_i[FLAG_C];
    assign v_s = flags_i[FLAG_V];

    // Decode the condition field against the current flags.
    always_comb begin
        pass_o = 1'b1;
        case (cond_i)
            COND_EQ: pass_o = z_s;
            COND_NE: pass_o = ~z_s;
            COND_CS: pass_o = c_s;
            COND_CC: pass_o = ~c_s;
            COND_MI: pass_o = n_s;
            COND_PL: pass_o = ~n_s;
            COND_VS: pass_o = v_s;
            COND_VC: pass_o = ~v_s;
            COND_HI: pass_o = ~z_s & c_s;
            COND_LS: pass_o = z_s | ~c_s;
            COND_GE: pass_o = (n_s == v_s);
            COND_LT: pass_o = (n_s != v_s);
            COND_GT: pass_o = ~z_s & (n_s == v_s);
            COND_LE: pass_o = z_s | (n_s != v_s);
            COND_AL: pass_o = 1'b1;
            COND_NV: pass_o = 1'b1;
            default: pass_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_exec_ctrl.sv
// cond_exec_ctrl: Execute-stage conditional-execution and branch-resolution
// controller. Holds the architectural NZCV register, gates Memory-stage
// controls on the condition result, and raises a one-cycle redirect when a
// committed branch disagrees with the predictor, then spends one cycle in
// RECOVER killing the wrong-path Execute/Fetch/Decode slots.
// Ports:
//   clk, reset_n (async, active-low)
//   valid_e, cond_e[3:0], flag_write_e[1:0], alu_flags_e[3:0]   Execute inputs
//   reg_write_e, mem_write_e, branch_e, pred_taken_e            decoded controls
//   stall_e, flush_e                                            hazard controls
//   cond_ex                     combinational condition result
//   flags_q[3:0]                architectural NZCV
//   valid_m, reg_write_m, mem_write_m    registered Memory-stage controls
//   redirect_valid, redirect_taken       registered branch-correction pulse
//   flush_fd                    kill Fetch/Decode while in RECOVER
//   perf_clr, perf_exec/skip/mispred[15:0]   performance counters
// Configuration: define COND_EXEC_PERF_EN to build the saturating counters;
// without it the perf_* outputs are constant zero and perf_clr is ignored.
module cond_exec_ctrl
    import cond_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_e,
    input  logic [3:0]  cond_e,
    input  logic [1:0]  flag_write_e,
    input  logic [3:0]  alu_flags_e,
    input  logic        reg_write_e,
    input  logic        mem_write_e,
    input  logic        branch_e,
    input  logic        pred_taken_e,
    input  logic        stall_e,
    input  logic        flush_e,
    output logic        cond_ex,
    output logic [3:0]  flags_q,
    output logic        valid_m,
    output logic        reg_write_m,
    output logic        mem_write_m,
    output logic        redirect_valid,
    output logic        redirect_taken,
    output logic        flush_fd,
    input  logic        perf_clr,
    output logic [15:0] perf_exec,
    output logic [15:0] perf_skip,
    output logic [15:0] perf_mispred
);

    state_t     state_q;
    state_t     state_d;
    logic       commit_s;
    logic       mispred_s;
    logic [3:0] flags_d;
    logic       valid_m_d;
    logic       reg_write_m_d;
    logic       mem_write_m_d;
    logic       redirect_valid_d;
    logic       redirect_taken_d;

    cond_eval u_cond_eval (
        .cond_i  (cond_e),
        .flags_i (flags_q),
        .pass_o  (cond_ex)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Commit qualification, mispredict detection and next state. Only RUN
    // can commit; the slot seen during RECOVER is on the wrong path.
    always_comb begin
        state_d   = state_q;
        commit_s  = 1'b0;
        mispred_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                commit_s  = valid_e & ~stall_e & ~flush_e;
                mispred_s = commit_s & branch_e & (cond_ex != pred_taken_e);
                if (mispred_s) begin
                    state_d = ST_RECOVER;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RECOVER: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign flush_fd = (state_q == ST_RECOVER);

    // Next values for flags, Memory-stage controls and redirect pulse.
    always_comb begin
        flags_d          = flags_q;
        valid_m_d        = valid_m;
        reg_write_m_d    = reg_write_m;
        mem_write_m_d    = mem_write_m;
        redirect_valid_d = mispred_s;
        redirect_taken_d = mispred_s & cond_ex;
        if (commit_s && cond_ex) begin
            if (flag_write_e[1]) begin
                flags_d[FLAG_N:FLAG_Z] = alu_flags_e[FLAG_N:FLAG_Z];
            end else begin
                flags_d[FLAG_N:FLAG_Z] = flags_q[FLAG_N:FLAG_Z];
            end
            if (flag_write_e[0]) begin
                flags_d[FLAG_C:FLAG_V] = alu_flags_e[FLAG_C:FLAG_V];
            end else begin
                flags_d[FLAG_C:FLAG_V] = flags_q[FLAG_C:FLAG_V];
            end
        end else begin
            flags_d = flags_q;
        end
        // A stalled slot leaves the Memory stage untouched.
        if (!stall_e) begin
            valid_m_d     = commit_s;
            reg_write_m_d = commit_s & cond_ex & reg_write_e;
            mem_write_m_d = commit_s & cond_ex & mem_write_e;
        end else begin
            valid_m_d     = valid_m;
            reg_write_m_d = reg_write_m;
            mem_write_m_d = mem_write_m;
        end
    end

    // Flag, Memory-stage and redirect registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q        <= 4'b0000;
            valid_m        <= 1'b0;
            reg_write_m    <= 1'b0;
            mem_write_m    <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_taken <= 1'b0;
        end else begin
            flags_q        <= flags_d;
            valid_m        <= valid_m_d;
            reg_write_m    <= reg_write_m_d;
            mem_write_m    <= mem_write_m_d;
            redirect_valid <= redirect_valid_d;
            redirect_taken <= redirect_taken_d;
        end
    end

`ifdef COND_EXEC_PERF_EN
    logic [15:0] perf_exec_q;
    logic [15:0] perf_skip_q;
    logic [15:0] perf_mispred_q;

    // Saturating performance counters; clear beats increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_exec_q    <= 16'h0000;
            perf_skip_q    <= 16'h0000;
            perf_mispred_q <= 16'h0000;
        end else if (perf_clr) begin
            perf_exec_q    <= 16'h0000;
            perf_skip_q    <= 16'h0000;
            perf_mispred_q <= 16'h0000;
        end else begin
            if (commit_s && cond_ex) begin
                perf_exec_q <= sat_inc16(perf_exec_q);
            end else begin
                perf_exec_q <= perf_exec_q;
            end
            if (commit_s && !cond_ex) begin
                perf_skip_q <= sat_inc16(perf_skip_q);
            end else begin
                perf_skip_q <= perf_skip_q;
            end
            if (mispred_s) begin
                perf_mispred_q <= sat_inc16(perf_mispred_q);
            end else begin
                perf_mispred_q <= perf_mispred_q;
            end
        end
    end

    assign perf_exec    = perf_exec_q;
    assign perf_skip    = perf_skip_q;
    assign perf_mispred = perf_mispred_q;
`else
    logic unused_perf_clr_s;

    assign unused_perf_clr_s = perf_clr;
    assign perf_exec         = 16'h0000;
    assign perf_skip         = 16'h0000;
    assign perf_mispred      = 16'h0000;
`endif

endmodule

// File: tb/tb_cond_exec_ctrl.sv
// tb_cond_exec_ctrl: directed self-checking bench for cond_exec_ctrl.
// A behavioural model computes the expected post-edge outputs when each
// Execute slot is driven; they are queued and popped/compared after the edge.
module tb_cond_exec_ctrl;

    logic        clk;
    logic        reset_n;
    logic        valid_e;
    logic [3:0]  cond_e;
    logic [1:0]  flag_write_e;
    logic [3:0]  alu_flags_e;
    logic        reg_write_e;
    logic        mem_write_e;
    logic        branch_e;
    logic        pred_taken_e;
    logic        stall_e;
    logic        flush_e;
    logic        cond_ex;
    logic [3:0]  flags_q;
    logic        valid_m;
    logic        reg_write_m;
    logic        mem_write_m;
    logic        redirect_valid;
    logic        redirect_taken;
    logic        flush_fd;
    logic        perf_clr;
    logic [15:0] perf_exec;
    logic [15:0] perf_skip;
    logic [15:0] perf_mispred;

    cond_exec_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .valid_e        (valid_e),
        .cond_e         (cond_e),
        .flag_write_e   (flag_write_e),
        .alu_flags_e    (alu_flags_e),
        .reg_write_e    (reg_write_e),
        .mem_write_e    (mem_write_e),
        .branch_e       (branch_e),
        .pred_taken_e   (pred_taken_e),
        .stall_e        (stall_e),
        .flush_e        (flush_e),
        .cond_ex        (cond_ex),
        .flags_q        (flags_q),
        .valid_m        (valid_m),
        .reg_write_m    (reg_write_m),
        .mem_write_m    (mem_write_m),
        .redirect_valid (redirect_valid),
        .redirect_taken (redirect_taken),
        .flush_fd       (flush_fd),
        .perf_clr       (perf_clr),
        .perf_exec      (perf_exec),
        .perf_skip      (perf_skip),
        .perf_mispred   (perf_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  flags;
        logic        vm;
        logic        rw;
        logic        mw;
        logic        rv;
        logic        rt;
        logic        ffd;
        logic [15:0] pe;
        logic [15:0] ps;
        logic [15:0] pm;
    } exp_t;

    exp_t sb[$];

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model state.
    logic [3:0]  m_flags;
    logic        m_vm, m_rw, m_mw, m_rv, m_rt, m_rec;
    logic [15:0] m_pe, m_ps, m_pm;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Condition evaluation in the ARM base/invert form.
    function automatic logic model_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (c[3:1] == 3'd7) return 1'b1;
        return base ^ c[0];
    endfunction

    function automatic logic [15:0] sat(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    task automatic model_reset();
        m_flags = 4'h0; m_vm = 0; m_rw = 0; m_mw = 0; m_rv = 0; m_rt = 0; m_rec = 0;
        m_pe = 16'h0; m_ps = 16'h0; m_pm = 16'h0;
    endtask

    task automatic drv(input logic v, input logic [3:0] c, input logic [1:0] fw,
                       input logic [3:0] af, input logic rw, input logic mw,
                       input logic br, input logic pt, input logic st, input logic fl);
        valid_e = v; cond_e = c; flag_write_e = fw; alu_flags_e = af;
        reg_write_e = rw; mem_write_e = mw; branch_e = br; pred_taken_e = pt;
        stall_e = st; flush_e = fl; perf_clr = 1'b0;
    endtask

    // One clock: predict, queue, clock, pop and compare.
    task automatic tick(input bit chk);
        exp_t e;
        logic pass, commit, mis;
        #1;
        pass = model_pass(cond_e, m_flags);
        if (chk) check("cond_ex", cond_ex, pass);
        commit = valid_e & ~stall_e & ~flush_e & ~m_rec;
        mis    = commit & branch_e & (pass != pred_taken_e);
        if (commit && pass) begin
            if (flag_write_e[1]) m_flags[3:2] = alu_flags_e[3:2];
            if (flag_write_e[0]) m_flags[1:0] = alu_flags_e[1:0];
        end
        if (!stall_e) begin
            m_vm = commit;
            m_rw = commit & pass & reg_write_e;
            m_mw = commit & pass & mem_write_e;
        end
        m_rv  = mis;
        m_rt  = mis & pass;
        m_rec = m_rec ? 1'b0 : mis;
`ifdef COND_EXEC_PERF_EN
        if (perf_clr) begin
            m_pe = 16'h0; m_ps = 16'h0; m_pm = 16'h0;
        end else begin
            if (commit && pass)  m_pe = sat(m_pe);
            if (commit && !pass) m_ps = sat(m_ps);
            if (mis)             m_pm = sat(m_pm);
        end
`endif
        e = '{flags: m_flags, vm: m_vm, rw: m_rw, mw: m_mw, rv: m_rv, rt: m_rt,
              ffd: m_rec, pe: m_pe, ps: m_ps, pm: m_pm};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (chk) begin
            check("flags_q", flags_q, e.flags);
            check("valid_m", valid_m, e.vm);
            check("reg_write_m", reg_write_m, e.rw);
            check("mem_write_m", mem_write_m, e.mw);
            check("redirect_valid", redirect_valid, e.rv);
            check("redirect_taken", redirect_taken, e.rt);
            check("flush_fd", flush_fd, e.ffd);
            check("perf_exec", perf_exec, e.pe);
            check("perf_skip", perf_skip, e.ps);
            check("perf_mispred", perf_mispred, e.pm);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, flags_q, 32'h0);
        check({tag, "_mctl"}, {valid_m, reg_write_m, mem_write_m}, 32'h0);
        check({tag, "_redir"}, {redirect_valid, redirect_taken}, 32'h0);
        check({tag, "_flush_fd"}, flush_fd, 32'h0);
        check({tag, "_perf"}, {perf_exec, perf_skip, perf_mispred}, 32'h0);
    endtask

    initial begin
        logic [3:0] pats [4];
        pats[0] = 4'b0000; pats[1] = 4'b0110; pats[2] = 4'b1001; pats[3] = 4'b1011;

        reset_n = 1'b0;
        drv(1'b0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        #12;
        check_all_zero("reset");
        reset_n = 1'b1;

        // CMP writes NZCV=0100, then EQ with reg write.
        drv(1'b1, 4'b1110, 2'b11, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick(1);
        check("cmp_flags", flags_q, 4'b0100);
        drv(1'b1, 4'b0000, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick(1);
        check("eq_cond_rw", {valid_m, reg_write_m}, 2'b11);

        // NE fails: slot valid but writes suppressed, flags untouched.
        drv(1'b1, 4'b0001, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick(1);
        check("ne_skip", {flags_q, valid_m, reg_write_m, mem_write_m}, 7'b0100_100);

        // Sweep every condition against several flag patterns.
        for (int p = 0; p < 4; p++) begin
            drv(1'b1, 4'b1110, 2'b11, pats[p], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick(1);
            for (int c = 0; c < 16; c++) begin
                drv(1'b0, 4'(c), 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick(1);
            end
        end

        // Partial flag writes: only CV, then only NZ.
        drv(1'b1, 4'b1110, 2'b01, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick(1);
        check("cv_only", flags_q, 4'b1010);
        drv(1'b1, 4'b1110, 2'b10, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick(1);
        check("nz_only", flags_q, 4'b0110);

        // Mispredicted GE branch with flags 1001, then wrong-path slot.
        drv(1'b1, 4'b1110, 2'b11, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick(1);
        drv(1'b1, 4'b1010, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick(1);
        check("br_redirect", {redirect_valid, redirect_taken, flush_fd}, 3'b111);
        drv(1'b1, 4'b1110, 2'b11, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick(1);
        check("wrong_path", {valid_m, redirect_valid, flush_fd, flags_q}, 7'b000_1001);

        // Correctly predicted branch: no redirect.
        drv(1'b1, 4'b1010, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick(1);
        check("br_correct", {redirect_valid, flush_fd}, 2'b00);

        // Same mispredict held by a 3-cycle stall behind a reg-writing instr.
        drv(1'b1, 4'b1110, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick(1);
        for (int s = 0; s < 3; s++) begin
            drv(1'b1, 4'b1010, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); tick(1);
            check("stall_hold", {redirect_valid, valid_m, reg_write_m, mem_write_m}, 4'b0110);
        end
        drv(1'b1, 4'b1010, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick(1);
        check("stall_release", {redirect_valid, redirect_taken}, 2'b11);
        drv(1'b0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick(1);

        // Flush with stall holds M; flush alone kills the slot.
        drv(1'b1, 4'b1110, 2'b00, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick(1);
        drv(1'b1, 4'b1110, 2'b11, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); tick(1);
        check("flush_stall_hold", {valid_m, reg_write_m, mem_write_m}, 3'b111);
        drv(1'b1, 4'b1110, 2'b11, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick(1);
        check("flush_kill", {valid_m, flags_q}, 5'b0_1001);

        // perf_clr with a concurrent commit (ignored when counters are absent).
        drv(1'b1, 4'b1110, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        perf_clr = 1'b1; tick(1);
        perf_clr = 1'b0;

        // Reset while in RECOVER.
        drv(1'b1, 4'b0000, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick(1);
        check("pre_reset_recover", flush_fd, 1'b1);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #2 reset_n = 1'b1;
        drv(1'b1, 4'b1110, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick(1);
        check("run_after_reset", {valid_m, reg_write_m, flush_fd}, 3'b110);

`ifdef COND_EXEC_PERF_EN
        // Saturation of perf_exec, then clear with a concurrent commit.
        drv(1'b1, 4'b1110, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) tick(0);
        check("perf_sat", perf_exec, 16'hFFFF);
        perf_clr = 1'b1; tick(1);
        check("perf_clr", perf_exec, 16'h0000);
        perf_clr = 1'b0;
`else
        drv(1'b1, 4'b0001, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick(1);
        check("perf_tied_zero", {perf_exec, perf_skip}, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
